decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the 5-stage RV32I core. Captures fetch outputs in an internal IF/ID register and decodes the held instruction into control fields and a sign-extended immediate. Reads operands from the integrated register file, which writeback also writes, and detects load-use hazards. On a hazard it stalls fetch and inserts a bubble toward execute.

## Interface
Parameters:
- RESET_PC, 32'h1000, PC value held in IF/ID while in reset
- NOP_INSTR, 32'h0000_0013, instruction word held in IF/ID on reset and flush (addi x0,x0,0)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset, synchronous, active-low
- instruction_i  input  data_t  fetched word, valid together with pc_i
- pc_i  input  addr_t  PC of instruction_i
- pc_next_i  input  addr_t  pc_i + 4
- jump_c_i  input  enable_t  redirect from execute; flush IF/ID
- ex_mem_ren_i  input  enable_t  instruction in execute is a load
- ex_rd_i  input  reg_addr_t  destination of instruction in execute
- wb_wen_i  input  enable_t  writeback register write enable
- wb_rd_i  input  reg_addr_t  writeback destination
- wb_data_i  input  data_t  writeback data
- stall_c_o  output  enable_t  to fetch stall_c_i; hold PC
- valid_o  output  1  decoded bundle is a real instruction
- pc_o, pc_next_o  output  addr_t  PC fields from IF/ID
- rs1_o, rs2_o, rd_o  output  reg_addr_t  register indices
- rs1_data_o, rs2_data_o  output  data_t  operand values
- imm_o  output  data_t  sign-extended immediate
- alu_op_o  output  alu_op_t  ALU operation
- alu_src_imm_o, alu_src_pc_o  output  1  operand B is imm / operand A is PC
- reg_wen_o, mem_ren_o, mem_wen_o  output  1  control bits
- funct3_o  output  3  forwarded for load/store width and branch type
- branch_o, jal_o, jalr_o  output  1  control-flow kind
- illegal_o  output  1  unrecognised opcode in a valid slot

## Operation
- IF/ID register holds instr, pc, pc_next, and valid. Priority: reset > jump_c_i (flush) > stall_c_o (hold) > load.
- Reset and flush load NOP_INSTR, RESET_PC / current pc_i, pc_next_i, and valid=0. A load sets valid=1.
- Decoding is purely combinational from IF/ID. It covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and FENCE (decoded as a NOP with valid=1).
- Immediate formats: I, S, B, U, J. Bit 31 is sign-extended; B and J immediates have bit 0 = 0.
- The opcode gates rs1 use and rs2 use. rs2 is used only by BRANCH, STORE, and OP.
- Hazard: stall_c_o = valid & ex_mem_ren_i & (ex_rd_i != 0) & ((rs1 used & ex_rd_i==rs1) | (rs2 used & ex_rd_i==rs2)).
- Hazard suppression: jump_c_i forces stall_c_o=0, because the flush wins.
- Bubble: when stall_c_o=1, or when valid=0, these outputs are forced to 0: valid_o, reg_wen_o, mem_ren_o, mem_wen_o, branch_o, jal_o, jalr_o, and illegal_o.
- Register file: 32x32, two read ports and one write port. x0 reads 0, and writes to x0 are ignored. Writes happen on posedge when wb_wen_i=1.
- Write-through: a same-cycle read of wb_rd_i (nonzero) with wb_wen_i=1 returns wb_data_i.
- Illegal opcode: illegal_o=1 and all side-effect controls are 0.

## Timing
- Fetch to decode latency: 1 cycle. A word presented at edge N appears decoded after edge N, combinationally valid before edge N+1.
- stall_c_o is combinational from IF/ID and execute inputs. IF/ID holds on the same edge that fetch holds its PC.
- Load-use stall lasts exactly 1 cycle for a single dependent instruction. The next cycle's execute slot holds the bubble, so ex_mem_ren_i=0.
- Flush takes effect at the edge where jump_c_i=1. The next cycle has valid_o=0.
- Reset values: IF/ID is NOP, RESET_PC, RESET_PC+4, valid=0. The register file is cleared to 0. All control outputs are 0, and stall_c_o=0.
- Reset mid-stall: the stall is cleared on the next edge.
- Flush during stall: the flush wins and IF/ID becomes invalid.

## Structure
- Shared package: reg_addr_t (5b), alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), and opcode localparams (OPC_LUI … OPC_FENCE). data_t, addr_t, and enable_t stay where they are.
- One sub-module: regfile, containing the 32x32 array, reset clear, x0 handling, and write-through.
- The decoder and immediate generator are combinational logic inside decode_stage.

## Test plan
- Reset then release: after 1 edge with instr 0x00500093 (addi x1,x0,5) at pc 0x1000, outputs are valid_o=1, rd_o=1, imm_o=5, alu_op_o=ADD, alu_src_imm_o=1, reg_wen_o=1, pc_o=0x1000.
- Write-through: present wb_wen_i=1, wb_rd_i=3, wb_data_i=0xDEADBEEF while IF/ID holds add x4,x3,x0. Required: rs1_data_o=0xDEADBEEF that cycle, and rs1 still reads it afterward.
- x0 write: write 0x1234 to x0, then read x0. Required: rs1_data_o=0.
- Load-use: IF/ID holds add x5,x2,x6, with ex_mem_ren_i=1 and ex_rd_i=6. Required: stall_c_o=1 and valid_o=0. On the next cycle with ex_mem_ren_i=0: stall_c_o=0, valid_o=1, same instruction. With ex_rd_i=0 there is no stall.
- Flush: jump_c_i=1 while fetch presents 0x00100113. Required: next cycle valid_o=0 and reg_wen_o=0. If jump_c_i=1 during a stall, stall_c_o=0.
- Immediates: beq with offset -4 gives imm_o=0xFFFFFFFC. jal with offset 0x800 gives imm_o=0x800. lui 0xABCDE gives imm_o=0xABCDE000. Opcode 0x7F gives illegal_o=1 with all side-effect controls 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared types, opcode constants and the ALU-operation helper for the RV32I decode stage.
//   No ports; imported by decode_stage and decode_stage_regfile.
package decode_stage_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
    typedef logic        enable_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd,
        AluPassB
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Arithmetic op from funct3/funct7[5]. SUB only exists for register-register ops;
    // for OP-IMM, bit 30 is part of the immediate except on the shift-right encoding.
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg_op);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (is_reg_op && funct7_b5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = funct7_b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile
//   32x32 integer register file: two combinational read ports, one write port.
//   x0 always reads 0 and ignores writes; a read of the register being written in the
//   same cycle returns the incoming data.
//   clk, rst_n        : clock, synchronous active-low reset (clears every register)
//   i_raddr1/2        : read addresses      o_rdata1/2 : read data
//   i_wen, i_waddr, i_wdata : write port, committed on posedge
module decode_stage_regfile
    import decode_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t i_raddr1,
    input  reg_addr_t i_raddr2,
    output data_t     o_rdata1,
    output data_t     o_rdata2,
    input  enable_t   i_wen,
    input  reg_addr_t i_waddr,
    input  data_t     i_wdata
);

    data_t r_regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0) begin
            o_rdata1 = '0;
        end else if (i_wen && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0) begin
            o_rdata2 = '0;
        end else if (i_wen && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   RV32I decode stage: IF/ID register, combinational decoder + immediate generator,
//   register-file read, and load-use hazard detection with bubble insertion.
//   Inputs : clk, rst_n (sync, active-low); instruction_i/pc_i/pc_next_i from fetch;
//            jump_c_i (flush) from execute; ex_mem_ren_i/ex_rd_i describe the instruction
//            in execute; wb_wen_i/wb_rd_i/wb_data_i write the register file.
//   Outputs: stall_c_o to fetch; decoded bundle (valid_o, pc fields, register indices and
//            data, imm_o, ALU controls, memory/branch controls, funct3_o, illegal_o).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter addr_t RESET_PC  = 32'h0000_1000,
    parameter data_t NOP_INSTR = 32'h0000_0013
) (
    input  logic      clk,
    input  logic      rst_n,
    input  data_t     instruction_i,
    input  addr_t     pc_i,
    input  addr_t     pc_next_i,
    input  enable_t   jump_c_i,
    input  enable_t   ex_mem_ren_i,
    input  reg_addr_t ex_rd_i,
    input  enable_t   wb_wen_i,
    input  reg_addr_t wb_rd_i,
    input  data_t     wb_data_i,
    output enable_t   stall_c_o,
    output logic      valid_o,
    output addr_t     pc_o,
    output addr_t     pc_next_o,
    output reg_addr_t rs1_o,
    output reg_addr_t rs2_o,
    output reg_addr_t rd_o,
    output data_t     rs1_data_o,
    output data_t     rs2_data_o,
    output data_t     imm_o,
    output alu_op_t   alu_op_o,
    output logic      alu_src_imm_o,
    output logic      alu_src_pc_o,
    output logic      reg_wen_o,
    output logic      mem_ren_o,
    output logic      mem_wen_o,
    output logic [2:0] funct3_o,
    output logic      branch_o,
    output logic      jal_o,
    output logic      jalr_o,
    output logic      illegal_o
);

    // IF/ID register
    data_t r_instr;
    addr_t r_pc;
    addr_t r_pc_next;
    logic  r_valid;

    logic w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr   <= NOP_INSTR;
            r_pc      <= RESET_PC;
            r_pc_next <= RESET_PC + 32'd4;
            r_valid   <= 1'b0;
        end else if (jump_c_i) begin
            r_instr   <= NOP_INSTR;
            r_pc      <= pc_i;
            r_pc_next <= pc_next_i;
            r_valid   <= 1'b0;
        end else if (!w_stall) begin
            r_instr   <= instruction_i;
            r_pc      <= pc_i;
            r_pc_next <= pc_next_i;
            r_valid   <= 1'b1;
        end
    end

    // Field extraction
    logic [6:0] w_opcode;
    reg_addr_t  w_rs1;
    reg_addr_t  w_rs2;
    reg_addr_t  w_rd;
    logic [2:0] w_funct3;
    logic       w_funct7_b5;

    assign w_opcode    = r_instr[6:0];
    assign w_rd        = r_instr[11:7];
    assign w_funct3    = r_instr[14:12];
    assign w_rs1       = r_instr[19:15];
    assign w_rs2       = r_instr[24:20];
    assign w_funct7_b5 = r_instr[30];

    // Immediate formats
    data_t w_imm_i;
    data_t w_imm_s;
    data_t w_imm_b;
    data_t w_imm_u;
    data_t w_imm_j;

    assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
    assign w_imm_u = {r_instr[31:12], 12'b0};
    assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                      r_instr[30:21], 1'b0};

    // Decoder
    data_t   w_imm;
    alu_op_t w_alu_op;
    logic    w_src_imm;
    logic    w_src_pc;
    logic    w_reg_wen;
    logic    w_mem_ren;
    logic    w_mem_wen;
    logic    w_branch;
    logic    w_jal;
    logic    w_jalr;
    logic    w_illegal;
    logic    w_rs1_used;
    logic    w_rs2_used;

    always_comb begin
        w_imm      = '0;
        w_alu_op   = AluAdd;
        w_src_imm  = 1'b0;
        w_src_pc   = 1'b0;
        w_reg_wen  = 1'b0;
        w_mem_ren  = 1'b0;
        w_mem_wen  = 1'b0;
        w_branch   = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_illegal  = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_imm     = w_imm_u;
                w_alu_op  = AluPassB;
                w_src_imm = 1'b1;
                w_reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm     = w_imm_u;
                w_src_imm = 1'b1;
                w_src_pc  = 1'b1;
                w_reg_wen = 1'b1;
            end
            OPC_JAL: begin
                // ALU forms the target pc + imm; rd receives pc_next.
                w_imm     = w_imm_j;
                w_src_imm = 1'b1;
                w_src_pc  = 1'b1;
                w_reg_wen = 1'b1;
                w_jal     = 1'b1;
            end
            OPC_JALR: begin
                w_imm      = w_imm_i;
                w_src_imm  = 1'b1;
                w_reg_wen  = 1'b1;
                w_jalr     = 1'b1;
                w_rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                // ALU compares rs1/rs2; execute adds imm to pc for the target.
                w_imm      = w_imm_b;
                w_alu_op   = AluSub;
                w_branch   = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                w_imm      = w_imm_i;
                w_src_imm  = 1'b1;
                w_reg_wen  = 1'b1;
                w_mem_ren  = 1'b1;
                w_rs1_used = 1'b1;
            end
            OPC_STORE: begin
                w_imm      = w_imm_s;
                w_src_imm  = 1'b1;
                w_mem_wen  = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm      = w_imm_i;
                w_alu_op   = alu_from_funct(w_funct3, w_funct7_b5, 1'b0);
                w_src_imm  = 1'b1;
                w_reg_wen  = 1'b1;
                w_rs1_used = 1'b1;
            end
            OPC_OP: begin
                w_alu_op   = alu_from_funct(w_funct3, w_funct7_b5, 1'b1);
                w_reg_wen  = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_FENCE: begin
                // Single-hart in-order core: fence has no effect.
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard; a flush discards the dependent instruction, so it never stalls.
    assign w_stall = r_valid && ex_mem_ren_i && (ex_rd_i != '0) && !jump_c_i &&
                     ((w_rs1_used && (ex_rd_i == w_rs1)) ||
                      (w_rs2_used && (ex_rd_i == w_rs2)));

    logic w_issue;
    assign w_issue = r_valid && !w_stall;

    decode_stage_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (rs1_data_o),
        .o_rdata2 (rs2_data_o),
        .i_wen    (wb_wen_i),
        .i_waddr  (wb_rd_i),
        .i_wdata  (wb_data_i)
    );

    assign stall_c_o     = w_stall;
    assign valid_o       = w_issue;
    assign pc_o          = r_pc;
    assign pc_next_o     = r_pc_next;
    assign rs1_o         = w_rs1;
    assign rs2_o         = w_rs2;
    assign rd_o          = w_rd;
    assign imm_o         = w_imm;
    assign alu_op_o      = w_alu_op;
    assign alu_src_imm_o = w_src_imm;
    assign alu_src_pc_o  = w_src_pc;
    assign funct3_o      = w_funct3;
    // Side-effect and control-flow bits are squashed for bubbles.
    assign reg_wen_o     = w_issue && w_reg_wen;
    assign mem_ren_o     = w_issue && w_mem_ren;
    assign mem_wen_o     = w_issue && w_mem_wen;
    assign branch_o      = w_issue && w_branch;
    assign jal_o         = w_issue && w_jal;
    assign jalr_o        = w_issue && w_jalr;
    assign illegal_o     = w_issue && w_illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic      clk;
    logic      rst_n;
    data_t     instruction_i;
    addr_t     pc_i;
    addr_t     pc_next_i;
    enable_t   jump_c_i;
    enable_t   ex_mem_ren_i;
    reg_addr_t ex_rd_i;
    enable_t   wb_wen_i;
    reg_addr_t wb_rd_i;
    data_t     wb_data_i;
    enable_t   stall_c_o;
    logic      valid_o;
    addr_t     pc_o;
    addr_t     pc_next_o;
    reg_addr_t rs1_o;
    reg_addr_t rs2_o;
    reg_addr_t rd_o;
    data_t     rs1_data_o;
    data_t     rs2_data_o;
    data_t     imm_o;
    alu_op_t   alu_op_o;
    logic      alu_src_imm_o;
    logic      alu_src_pc_o;
    logic      reg_wen_o;
    logic      mem_ren_o;
    logic      mem_wen_o;
    logic [2:0] funct3_o;
    logic      branch_o;
    logic      jal_o;
    logic      jalr_o;
    logic      illegal_o;

    int checks   = 0;
    int failures = 0;

    decode_stage #(
        .RESET_PC  (32'h0000_1000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .pc_next_i     (pc_next_i),
        .jump_c_i      (jump_c_i),
        .ex_mem_ren_i  (ex_mem_ren_i),
        .ex_rd_i       (ex_rd_i),
        .wb_wen_i      (wb_wen_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .stall_c_o     (stall_c_o),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .rd_o          (rd_o),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .imm_o         (imm_o),
        .alu_op_o      (alu_op_o),
        .alu_src_imm_o (alu_src_imm_o),
        .alu_src_pc_o  (alu_src_pc_o),
        .reg_wen_o     (reg_wen_o),
        .mem_ren_o     (mem_ren_o),
        .mem_wen_o     (mem_wen_o),
        .funct3_o      (funct3_o),
        .branch_o      (branch_o),
        .jal_o         (jal_o),
        .jalr_o        (jalr_o),
        .illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic fetch(input data_t instr, input addr_t pc);
        instruction_i = instr;
        pc_i          = pc;
        pc_next_i     = pc + 32'd4;
    endtask

    // Side-effect / control-flow bits packed for one-shot comparison.
    function automatic logic [31:0] ctl();
        return {26'd0, reg_wen_o, mem_ren_o, mem_wen_o, branch_o, jal_o, jalr_o};
    endfunction

    initial begin
        rst_n        = 1'b0;
        jump_c_i     = 1'b0;
        ex_mem_ren_i = 1'b0;
        ex_rd_i      = '0;
        wb_wen_i     = 1'b0;
        wb_rd_i      = '0;
        wb_data_i    = '0;
        fetch(32'h0050_0093, 32'h1000);            // addi x1,x0,5

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_stall", 32'(stall_c_o), 32'd0);
        chk("rst_pc", pc_o, 32'h1000);
        chk("rst_pc_next", pc_next_o, 32'h1004);
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_rd_nop", 32'(rd_o), 32'd0);

        // Release: addi x1,x0,5
        rst_n = 1'b1;
        tick();
        #1;
        chk("addi_valid", 32'(valid_o), 32'd1);
        chk("addi_rd", 32'(rd_o), 32'd1);
        chk("addi_imm", imm_o, 32'd5);
        chk("addi_alu", 32'(alu_op_o), 32'(AluAdd));
        chk("addi_src_imm", 32'(alu_src_imm_o), 32'd1);
        chk("addi_reg_wen", 32'(reg_wen_o), 32'd1);
        chk("addi_pc", pc_o, 32'h1000);

        // Write-through: add x4,x3,x0 while writing x3
        fetch(32'h0001_8233, 32'h1004);
        tick();
        wb_wen_i  = 1'b1;
        wb_rd_i   = 5'd3;
        wb_data_i = 32'hDEAD_BEEF;
        #1;
        chk("wt_same_cycle", rs1_data_o, 32'hDEAD_BEEF);
        chk("wt_src_imm", 32'(alu_src_imm_o), 32'd0);
        tick();
        wb_wen_i = 1'b0;
        #1;
        chk("wt_after", rs1_data_o, 32'hDEAD_BEEF);

        // x0 write is discarded: add x4,x0,x0
        fetch(32'h0000_0233, 32'h1008);
        wb_wen_i  = 1'b1;
        wb_rd_i   = 5'd0;
        wb_data_i = 32'h0000_1234;
        tick();
        #1;
        chk("x0_bypass", rs1_data_o, 32'd0);
        wb_wen_i = 1'b0;
        tick();
        #1;
        chk("x0_read", rs1_data_o, 32'd0);

        // Load-use on rs2: add x5,x2,x6 with a load to x6 in execute
        fetch(32'h0061_02B3, 32'h1010);
        tick();
        ex_mem_ren_i = 1'b1;
        ex_rd_i      = 5'd6;
        fetch(32'h0010_0113, 32'h1014);            // addi x2,x0,1 waiting in fetch
        #1;
        chk("lu_stall", 32'(stall_c_o), 32'd1);
        chk("lu_valid", 32'(valid_o), 32'd0);
        chk("lu_ctl", ctl(), 32'd0);
        tick();
        ex_mem_ren_i = 1'b0;
        #1;
        chk("lu_release_stall", 32'(stall_c_o), 32'd0);
        chk("lu_release_valid", 32'(valid_o), 32'd1);
        chk("lu_hold_rd", 32'(rd_o), 32'd5);
        chk("lu_hold_pc", pc_o, 32'h1010);
        ex_mem_ren_i = 1'b1;
        ex_rd_i      = 5'd0;
        #1;
        chk("lu_x0_nostall", 32'(stall_c_o), 32'd0);
        ex_rd_i = 5'd2;
        #1;
        chk("lu_rs1_stall", 32'(stall_c_o), 32'd1);

        // Flush during stall
        jump_c_i = 1'b1;
        #1;
        chk("flush_kills_stall", 32'(stall_c_o), 32'd0);
        tick();
        jump_c_i     = 1'b0;
        ex_mem_ren_i = 1'b0;
        #1;
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_reg_wen", 32'(reg_wen_o), 32'd0);
        chk("flush_pc", pc_o, 32'h1014);
        tick();
        #1;
        chk("post_flush_valid", 32'(valid_o), 32'd1);
        chk("post_flush_rd", 32'(rd_o), 32'd2);

        // beq x0,x0,-4
        fetch(32'hFE00_0EE3, 32'h1018);
        tick();
        #1;
        chk("beq_imm", imm_o, 32'hFFFF_FFFC);
        chk("beq_ctl", ctl(), 32'b000100);
        chk("beq_alu", 32'(alu_op_o), 32'(AluSub));

        // jal x0,0x800
        fetch(32'h0010_006F, 32'h101C);
        tick();
        #1;
        chk("jal_imm", imm_o, 32'h0000_0800);
        chk("jal_ctl", ctl(), 32'b100010);

        // sw x6,-8(x1)
        fetch(32'hFE60_AC23, 32'h1020);
        tick();
        #1;
        chk("sw_imm", imm_o, 32'hFFFF_FFF8);
        chk("sw_ctl", ctl(), 32'b001000);
        chk("sw_funct3", 32'(funct3_o), 32'd2);

        // lui x1,0xABCDE; rs1 field is 27 but unused, so a load to x27 must not stall
        fetch(32'hABCD_E0B7, 32'h1024);
        tick();
        ex_mem_ren_i = 1'b1;
        ex_rd_i      = 5'd27;
        #1;
        chk("lui_imm", imm_o, 32'hABCD_E000);
        chk("lui_alu", 32'(alu_op_o), 32'(AluPassB));
        chk("lui_nostall", 32'(stall_c_o), 32'd0);
        ex_mem_ren_i = 1'b0;

        // Illegal opcode 0x7F
        fetch(32'h0000_007F, 32'h1028);
        tick();
        #1;
        chk("ill_flag", 32'(illegal_o), 32'd1);
        chk("ill_ctl", ctl(), 32'd0);

        // Reset while stalled
        fetch(32'h0061_02B3, 32'h102C);
        tick();
        ex_mem_ren_i = 1'b1;
        ex_rd_i      = 5'd6;
        #1;
        chk("rs_pre_stall", 32'(stall_c_o), 32'd1);
        rst_n = 1'b0;
        tick();
        #1;
        chk("rs_stall_cleared", 32'(stall_c_o), 32'd0);
        chk("rs_valid", 32'(valid_o), 32'd0);
        chk("rs_pc", pc_o, 32'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
